// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/LOOKUP/HALT FSM with table-driven relative branches.
// Latency: sequential PC +1 per cycle; taken branch lands 2 cycles after BranchEn is sampled.
// Backpressure: Stall freezes PC, LutIdx, state (and BranchCnt); optional counter via BRANCH_COUNT_EN.
module pc_branch_ctrl #(
    parameter int PC_W       = 10,
    parameter int IDX_W      = 8,
    parameter int START_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic [IDX_W-1:0]  BranchIdx,
    input  logic              HaltReq,
    output logic [IDX_W-1:0]  LutIdx,
    input  logic [PC_W-1:0]   LutOut,
`ifdef BRANCH_COUNT_EN
    output logic [15:0]       BranchCnt,
`endif
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LOOKUP = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [IDX_W-1:0]   lut_idx_q, lut_idx_d;
    logic               running_q, done_q;
`ifdef BRANCH_COUNT_EN
    logic [15:0]        cnt_q, cnt_d;
`endif

    // Next-state decode; Stall overrides everything so all _d default to hold.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        lut_idx_d = lut_idx_q;
`ifdef BRANCH_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (!Stall) begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state_d = S_RUN;
                        pc_d    = START_PC;
`ifdef BRANCH_COUNT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                S_RUN: begin
                    if (HaltReq) begin
                        state_d = S_HALT;
                    end else if (BranchEn) begin
                        state_d   = S_LOOKUP;
                        lut_idx_d = BranchIdx;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                S_LOOKUP: begin
                    // Offset and PC share a width, so a plain add is the
                    // sign-extended modulo-2^PC_W sum in both directions.
                    pc_d    = pc_q + LutOut;
                    state_d = S_RUN;
`ifdef BRANCH_COUNT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, PC, table index and registered status flags; async reset drops any pending branch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= START_PC;
            lut_idx_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BRANCH_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lut_idx_q <= lut_idx_d;
            running_q <= (state_d == S_RUN) || (state_d == S_LOOKUP);
            done_q    <= (state_d == S_HALT);
`ifdef BRANCH_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ProgCtr = pc_q;
    assign LutIdx  = lut_idx_q;
    assign Running = running_q;
    assign Done    = done_q;
`ifdef BRANCH_COUNT_EN
    assign BranchCnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed scenarios plus random traffic vs. a behavioural model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// BranchCnt is checked only when BRANCH_COUNT_EN is defined.
module tb_pc_branch_ctrl;

    localparam int PC_W  = 10;
    localparam int IDX_W = 8;
    localparam int START = 0;
    localparam int MOD   = 1 << PC_W;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Start, Stall, BranchEn, HaltReq;
    logic [IDX_W-1:0]  BranchIdx;
    logic [IDX_W-1:0]  LutIdx;
    logic [PC_W-1:0]   LutOut;
    logic [PC_W-1:0]   ProgCtr;
    logic              Running, Done;
`ifdef BRANCH_COUNT_EN
    logic [15:0]       BranchCnt;
`endif

    // Branch offset table served combinationally for the DUT's index
    logic signed [PC_W-1:0] lut [256];
    assign LutOut = lut[LutIdx];

    always #5 Clk = ~Clk;

    pc_branch_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .START_ADDR(START)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Stall     (Stall),
        .BranchEn  (BranchEn),
        .BranchIdx (BranchIdx),
        .HaltReq   (HaltReq),
        .LutIdx    (LutIdx),
        .LutOut    (LutOut),
`ifdef BRANCH_COUNT_EN
        .BranchCnt (BranchCnt),
`endif
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 = stopped, 1 = executing, 2 = halted
    int m_mode, m_pc, m_idx, m_cnt;
    bit m_pend;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = START; m_idx = 0; m_cnt = 0; m_pend = 1'b0;
    endtask

    task automatic model_clk(input bit st, input bit sl, input bit br, input int idx, input bit hl);
        int off;
        if (sl) return;
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = START; m_pend = 1'b0; m_cnt = 0;
            end
        end else if (m_pend) begin
            off    = lut[m_idx];
            m_pc   = wrap(m_pc + off);
            m_pend = 1'b0;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (hl) begin
            m_mode = 2;
        end else if (br) begin
            m_pend = 1'b1;
            m_idx  = idx;
        end else begin
            m_pc = wrap(m_pc + 1);
        end
    endtask

    task automatic compare_all();
        chk("pc",      int'(ProgCtr), m_pc);
        chk("lut_idx", int'(LutIdx),  m_idx);
        chk("running", int'(Running), (m_mode == 1) ? 1 : 0);
        chk("done",    int'(Done),    (m_mode == 2) ? 1 : 0);
`ifdef BRANCH_COUNT_EN
        chk("branch_cnt", int'(BranchCnt), m_cnt);
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare
    task automatic step(input bit st, input bit sl, input bit br, input int idx, input bit hl);
        Start = st; Stall = sl; BranchEn = br; BranchIdx = IDX_W'(idx); HaltReq = hl;
        @(posedge Clk);
        model_clk(st, sl, br, idx, hl);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) lut[i] = '0;
        Reset_n = 1'b0; Start = 0; Stall = 0; BranchEn = 0; BranchIdx = '0; HaltReq = 0;
        model_reset();
        #1;
        chk("rst_pc",      int'(ProgCtr), 0);
        chk("rst_lut_idx", int'(LutIdx),  0);
        chk("rst_running", int'(Running), 0);
        chk("rst_done",    int'(Done),    0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(2);
        chk("idle_hold_pc", int'(ProgCtr), 0);

        // Start then sequential fetch 0..5
        step(1, 0, 0, 0, 0);
        chk("start_pc", int'(ProgCtr), 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("seq_pc", int'(ProgCtr), i);
        end
        chk("seq_running", int'(Running), 1);
        chk("seq_done",    int'(Done),    0);

        // Reach 375, then branch by -356 -> 19 with 2-cycle latency
        lut[7] = 10'sd370;
        step(0, 0, 1, 7, 0); step(0, 0, 0, 0, 0);
        chk("pc_375", int'(ProgCtr), 375);
        lut[1] = -10'sd356;
        step(0, 0, 1, 1, 0);
        chk("br_lut_idx", int'(LutIdx),  1);
        chk("br_pc_hold", int'(ProgCtr), 375);
        step(1, 0, 1, 9, 1);   // Start/BranchEn/HaltReq ignored in LOOKUP
        chk("br_pc_19",   int'(ProgCtr), 19);

        // Wrap in both directions
        lut[2] = -10'sd23; step(0, 0, 1, 2, 0); step(0, 0, 0, 0, 0);
        chk("pc_1020", int'(ProgCtr), 1020);
        lut[3] = 10'sd10;  step(0, 0, 1, 3, 0); step(0, 0, 0, 0, 0);
        chk("wrap_up_6", int'(ProgCtr), 6);
        lut[4] = -10'sd3;  step(0, 0, 1, 4, 0); step(0, 0, 0, 0, 0);
        lut[5] = -10'sd5;  step(0, 0, 1, 5, 0); step(0, 0, 0, 0, 0);
        chk("wrap_dn_1022", int'(ProgCtr), 1022);

        // Stall for 3 cycles inside LOOKUP
        lut[6] = 10'sd42;
        step(0, 0, 1, 6, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 11, 1);
            chk("stall_pc",      int'(ProgCtr), 1022);
            chk("stall_lut_idx", int'(LutIdx),  6);
        end
        step(0, 0, 0, 0, 0);
        chk("stall_release_pc", int'(ProgCtr), 40);

        // HaltReq wins over BranchEn, then restart
        step(0, 0, 1, 12, 1);
        chk("halt_pc",   int'(ProgCtr), 40);
        chk("halt_done", int'(Done),    1);
        chk("halt_lut_idx", int'(LutIdx), 6);
        step(0, 0, 1, 13, 0);
        chk("halt_hold_pc", int'(ProgCtr), 40);
        step(1, 0, 0, 0, 0);
        chk("restart_pc",      int'(ProgCtr), 0);
        chk("restart_running", int'(Running), 1);

        // Three completed branches, then async reset during a lookup
        lut[0] = 10'sd1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
        end
        chk("three_br_pc", int'(ProgCtr), 3);
`ifdef BRANCH_COUNT_EN
        chk("three_br_cnt", int'(BranchCnt), 3);
`endif
        lut[8] = 10'sd100;
        step(0, 0, 1, 8, 0);
        #2 Reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pc",      int'(ProgCtr), START);
        chk("arst_lut_idx", int'(LutIdx),  0);
        chk("arst_running", int'(Running), 0);
        chk("arst_done",    int'(Done),    0);
`ifdef BRANCH_COUNT_EN
        chk("arst_cnt", int'(BranchCnt), 0);
`endif
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle(3);
        chk("post_arst_pc", int'(ProgCtr), START);

        // Random traffic against the model
        for (int i = 0; i < 256; i++) lut[i] = PC_W'($urandom);
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 40) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter and branch-offset width.
REQ-002 SHALL have parameter IDX_W, default 8, branch lookup-table index width.
REQ-003 SHALL have parameter START_ADDR, default 0, PC value loaded on reset and on Start.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Start  input  1  one-cycle pulse; begins program execution from START_ADDR.
REQ-007 Stall  input  1  holds PC and FSM state while high.
REQ-008 BranchEn  input  1  current instruction is a taken branch.
REQ-009 BranchIdx  input  IDX_W  lookup-table index supplied with BranchEn.
REQ-010 HaltReq  input  1  current instruction is halt.
REQ-011 LutIdx  output  IDX_W  registered index driven to the branch lookup table.
REQ-012 LutOut  input  PC_W  signed two's-complement PC offset returned combinationally for LutIdx.
REQ-013 ProgCtr  output  PC_W  current instruction address.
REQ-014 Running  output  1  high in RUN or LOOKUP.
REQ-015 Done  output  1  high in HALT.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, LOOKUP, HALT.
REQ-017 IDLE: ProgCtr held; Start -> RUN with ProgCtr <= START_ADDR.
REQ-018 RUN, Stall low, HaltReq high -> HALT, ProgCtr unchanged; HaltReq has priority over BranchEn.
REQ-019 RUN, Stall low, BranchEn high -> LOOKUP, LutIdx <= BranchIdx, ProgCtr unchanged.
REQ-020 RUN, Stall low, neither asserted -> ProgCtr <= ProgCtr + 1, stay RUN.
REQ-021 LOOKUP, Stall low -> ProgCtr <= ProgCtr + sign-extended LutOut, return to RUN; branch latency exactly 2 cycles from BranchEn sample to new ProgCtr.
REQ-022 LOOKUP SHALL ignore BranchEn, HaltReq, BranchIdx.
REQ-023 All PC arithmetic SHALL be modulo 2^PC_W (wrap both directions, no saturation, no error flag).
REQ-024 Stall high in any state SHALL freeze ProgCtr, LutIdx, and state; Stall has priority over all other inputs except Reset_n.
REQ-025 HALT: ProgCtr held, Done high; Start -> RUN with ProgCtr <= START_ADDR; other inputs ignored.
REQ-026 Start SHALL be ignored in RUN and LOOKUP.
REQ-027 LutIdx SHALL change only on entry to LOOKUP.

Reset
REQ-028 Reset_n low SHALL immediately force state IDLE, ProgCtr = START_ADDR, LutIdx = 0, Running = 0, Done = 0, independent of Clk.
REQ-029 Reset_n asserted mid-LOOKUP SHALL discard the pending branch; no offset applied after release.
REQ-030 First state change after Reset_n deassertion SHALL occur on a rising Clk edge only.

Configuration
REQ-031 Macro BRANCH_COUNT_EN SHALL, when defined, add output BranchCnt (16 bits): count of completed LOOKUP->RUN transitions, cleared by reset and by Start, wrapping at 2^16.
REQ-032 Without BRANCH_COUNT_EN, port BranchCnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, Start pulse, 5 idle cycles -> ProgCtr 0,1,2,3,4,5; Running=1, Done=0.
REQ-034 ProgCtr=375, BranchEn=1, BranchIdx=1, LutOut=-356 -> LutIdx=1 next cycle, ProgCtr=19 the cycle after.
REQ-035 ProgCtr=1020, BranchEn with LutOut=+10 -> ProgCtr=6 (wrap); ProgCtr=3 with LutOut=-5 -> 1022.
REQ-036 Stall high 3 cycles during LOOKUP -> ProgCtr and LutIdx frozen, offset applied on first cycle after Stall falls.
REQ-037 BranchEn and HaltReq together at ProgCtr=40 -> HALT, ProgCtr=40, Done=1; then Start -> ProgCtr=0, Running=1.
REQ-038 Reset_n low asynchronously mid-LOOKUP -> outputs at reset values before next Clk edge; with BRANCH_COUNT_EN, three completed branches give BranchCnt=3, reset gives 0.
